// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment capture path.
// Holds the glyph table, the idle line levels and the field widths.
package seg7_pkg;

  localparam int DIGITS = 4;
  localparam int SEG_W  = 8;

  localparam logic [3:0] IDLE_AN  = 4'hF;
  localparam logic [7:0] IDLE_SEG = 8'hFF;

  // Lit-segment patterns (gfedcba, 1 = lit) indexed by hex value.
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_scan_capture_if.sv
// Display-side bundle: the raw active-low display lines plus the recovered state.
// master drives the display lines, slave is the capture block.
interface seg7_scan_capture_if;
  import seg7_pkg::*;

  logic [SEG_W-1:0]    SEGMENT;
  logic [DIGITS-1:0]   AN;
  logic [4*DIGITS-1:0] digits;
  logic [DIGITS-1:0]   points;
  logic [DIGITS-1:0]   blank;
  logic [DIGITS-1:0]   seg_err;
  logic                an_err;
  logic                frame_done;

  modport master (
    output SEGMENT, AN,
    input  digits, points, blank, seg_err, an_err, frame_done
  );

  modport slave (
    input  SEGMENT, AN,
    output digits, points, blank, seg_err, an_err, frame_done
  );

endinterface

// File: rtl/seg7_pattern_decode.sv
// Maps a 7-bit lit-segment set (gfedcba) back to its hex value.
// Flags an empty set as blank and any non-glyph pattern as an error.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] lit,
  output logic [3:0] value,
  output logic       is_blank,
  output logic       is_err
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    value    = '0;
    is_blank = (lit == 7'h00);
    is_err   = ~is_blank;
    for (int v = 0; v < 16; v++) begin
      if (lit == GLYPH[v]) begin
        value  = 4'(v);
        is_err = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Samples asynchronous AN/SEGMENT lines, waits for them to settle and
// recovers the value, point and status of each scanned digit.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  seg7_scan_capture_if.slave bus
);

  localparam int         W        = DIGITS + SEG_W;
  localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_FIRE = 8'(STABLE_CYCLES - 1);

  logic [W-1:0]        sync1, s, cand_q, cap_val;
  logic [7:0]          cnt;
  logic                cap_q;
  logic [DIGITS-1:0]   seen_q, seen_next, sel;
  logic [1:0]          idx;
  logic [3:0]          base;
  logic                single;
  logic [4*DIGITS-1:0] digits_q;
  logic [DIGITS-1:0]   points_q, blank_q, err_q;
  logic                an_err_q, frame_done_q;
  logic [3:0]          value;
  logic                is_blank, is_err;

  // NOTE: the synchronizer and comparison registers reset to the idle line
  // levels rather than zero, otherwise an all-digits-lit pattern would be captured.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= {IDLE_AN, IDLE_SEG};
      s       <= {IDLE_AN, IDLE_SEG};
      cand_q  <= {IDLE_AN, IDLE_SEG};
      cap_val <= {IDLE_AN, IDLE_SEG};
      cnt     <= '0;
      cap_q   <= 1'b0;
    end else begin
      sync1   <= {bus.AN, bus.SEGMENT};
      s       <= sync1;
      cand_q  <= s;
      cap_val <= cand_q;
      if (s != cand_q)        cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 8'd1;
      // Fires exactly once, on the step into saturation.
      cap_q   <= (s == cand_q) && (cnt == CNT_FIRE);
    end
  end

  assign sel    = ~cap_val[W-1:SEG_W];
  assign single = ($countones(sel) == 1);
  assign base   = {idx, 2'b00};

  always_comb begin
    idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel[i]) idx = 2'(i);
    end
  end

  assign seen_next = seen_q | (DIGITS'(1) << idx);

  seg7_pattern_decode u_decode (
    .lit      (~cap_val[6:0]),
    .value    (value),
    .is_blank (is_blank),
    .is_err   (is_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q     <= '0;
      points_q     <= '0;
      blank_q      <= '0;
      err_q        <= '0;
      seen_q       <= '0;
      an_err_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      an_err_q     <= 1'b0;
      frame_done_q <= 1'b0;
      if (cap_q && (sel != '0)) begin
        if (!single) begin
          an_err_q <= 1'b1;
        end else begin
          digits_q[base +: 4] <= value;
          points_q[idx]       <= ~cap_val[7];
          blank_q[idx]        <= is_blank;
          err_q[idx]          <= is_err;
          if (seen_next == {DIGITS{1'b1}}) begin
            frame_done_q <= 1'b1;
            seen_q       <= '0;
          end else begin
            seen_q <= seen_next;
          end
        end
      end
    end
  end

  assign bus.digits     = digits_q;
  assign bus.points     = points_q;
  assign bus.blank      = blank_q;
  assign bus.seg_err    = err_q;
  assign bus.an_err     = an_err_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture with STABLE_CYCLES = 4.
// Drives on the falling edge, samples 1 time unit after the rising edge.
module tb_seg7_scan_capture;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   fd_cnt   = 0;
  int   ae_cnt   = 0;
  int   mark;

  // SEGMENT encodings: {~point, ~lit[6:0]}
  localparam logic [7:0] SEG_3    = 8'hB0;
  localparam logic [7:0] SEG_5    = 8'h92;
  localparam logic [7:0] SEG_A    = 8'h88;
  localparam logic [7:0] SEG_D_P  = 8'h21;
  localparam logic [7:0] SEG_8    = 8'h80;
  localparam logic [7:0] SEG_ERR  = 8'hFE;
  localparam logic [7:0] SEG_NONE = 8'hFF;

  seg7_scan_capture_if bus ();

  seg7_scan_capture #(.STABLE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (bus.frame_done === 1'b1) fd_cnt++;
    if (bus.an_err === 1'b1)     ae_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic show(input logic [3:0] an, input logic [7:0] seg, input int cycles);
    @(negedge clk);
    bus.AN      = an;
    bus.SEGMENT = seg;
    repeat (cycles - 1) @(negedge clk);
  endtask

  initial begin
    bus.AN      = 4'hF;
    bus.SEGMENT = 8'hFF;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_digits", 32'(bus.digits), 32'h0);
    check("reset_flags", {bus.points, bus.blank, bus.seg_err}, 32'h0);
    rst_n = 1'b1;

    // Idle after reset
    repeat (50) @(negedge clk);
    check("idle_digits", 32'(bus.digits), 32'h0);
    check("idle_flags", {bus.points, bus.blank, bus.seg_err}, 32'h0);
    check("idle_pulses", 32'(fd_cnt + ae_cnt), 32'h0);

    // Static digit 0 showing 5, latency check at k+6 / k+7
    @(negedge clk);
    bus.AN      = 4'b1110;
    bus.SEGMENT = SEG_5;
    repeat (7) @(posedge clk);
    #1 check("lat_k6_not_yet", 32'(bus.digits[3:0]), 32'h0);
    @(posedge clk);
    #1 check("lat_k7_digit0", 32'(bus.digits[3:0]), 32'h5);
    check("static_flags", {bus.points[0], bus.blank[0], bus.seg_err[0]}, 32'h0);
    repeat (40) @(negedge clk);
    check("static_no_frame", 32'(fd_cnt), 32'h0);

    // Full scan, two passes: 3, A, d(point), 8
    mark = fd_cnt;
    for (int p = 0; p < 2; p++) begin
      show(4'b1110, SEG_3,   20);
      show(4'b1101, SEG_A,   20);
      show(4'b1011, SEG_D_P, 20);
      show(4'b0111, SEG_8,   20);
    end
    repeat (10) @(negedge clk);
    check("scan_digits", 32'(bus.digits), 32'h8DA3);
    check("scan_points", 32'(bus.points), 32'h4);
    check("scan_blank_err", {bus.blank, bus.seg_err}, 32'h0);
    check("scan_frames", 32'(fd_cnt - mark), 32'd2);

    // Error on digit 1, blank on digit 2, then finish the frame
    mark = fd_cnt;
    show(4'b1101, SEG_ERR,  20);
    show(4'b1011, SEG_NONE, 20);
    repeat (5) @(negedge clk);
    check("err_seg_err", 32'(bus.seg_err), 32'h2);
    check("err_blank", 32'(bus.blank), 32'h4);
    check("err_digits", 32'(bus.digits), 32'h8003);
    check("err_points", 32'(bus.points), 32'h0);
    check("err_partial_frame", 32'(fd_cnt - mark), 32'd0);
    show(4'b1110, SEG_3, 20);
    show(4'b0111, SEG_8, 20);
    repeat (5) @(negedge clk);
    check("err_frame_done", 32'(fd_cnt - mark), 32'd1);

    // Glitch: 3-cycle SEGMENT change on digit 0, then idle
    show(4'b1110, SEG_3, 20);
    show(4'b1110, SEG_5, 3);
    show(4'hF, SEG_NONE, 20);
    check("glitch_digit0", 32'(bus.digits[3:0]), 32'h3);

    // Two AN bits low: an_err only
    mark = ae_cnt;
    show(4'b1100, SEG_5, 20);
    show(4'hF, SEG_NONE, 10);
    check("an_err_pulse", 32'(ae_cnt - mark), 32'd1);
    check("an_err_digits", 32'(bus.digits), 32'h8003);
    mark = fd_cnt;
    show(4'b1101, SEG_A,   20);
    show(4'b1011, SEG_D_P, 20);
    repeat (5) @(negedge clk);
    check("an_err_seen_kept", 32'(fd_cnt - mark), 32'd0);
    show(4'b0111, SEG_8, 20);
    repeat (5) @(negedge clk);
    check("an_err_frame", 32'(fd_cnt - mark), 32'd1);
    check("an_err_final", 32'(bus.digits), 32'h8DA3);

    // Reset mid-frame
    show(4'b1110, SEG_3, 20);
    show(4'b1101, SEG_A, 20);
    #2 rst_n = 1'b0;
    #1 check("midreset_digits", 32'(bus.digits), 32'h0);
    check("midreset_flags", {bus.points, bus.blank, bus.seg_err}, 32'h0);
    bus.AN      = 4'hF;
    bus.SEGMENT = SEG_NONE;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mark = fd_cnt;
    show(4'b1011, SEG_D_P, 20);
    show(4'b0111, SEG_8,   20);
    repeat (5) @(negedge clk);
    check("midreset_no_frame", 32'(fd_cnt - mark), 32'd0);
    check("midreset_digits2", 32'(bus.digits), 32'h8D00);
    show(4'b1110, SEG_3, 20);
    show(4'b1101, SEG_A, 20);
    repeat (5) @(negedge clk);
    check("midreset_frame", 32'(fd_cnt - mark), 32'd1);
    check("midreset_final", 32'(bus.digits), 32'h8DA3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receiving end of the board's 7-segment interface: samples the active-low SEGMENT[7:0] and AN[3:0] lines and recovers the hex digit, point and status of each of the 4 digit positions.
- Sits on the bench/loopback side of any display driver, either a static single-digit decoder or a scanned multi-digit driver.
- Lets self-check logic compare the digits shown on the display against the intended values.

Parameters:
- STABLE_CYCLES, 4, consecutive clk cycles {AN,SEGMENT} must hold unchanged before a capture; legal range 1..255.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- SEGMENT  in  8  active-low: [0]=a .. [6]=g, [7]=p; 0 = lit; asynchronous to clk
- AN  in  4  active-low digit enables; AN[i]=0 selects digit i; asynchronous to clk
- digits  out  16  nibble i at [4i+3:4i] = last decoded value of digit i
- points  out  4  points[i]=1 when digit i's decimal point was lit at last capture
- blank  out  4  blank[i]=1 when digit i had no segment lit at last capture
- seg_err  out  4  seg_err[i]=1 when digit i's pattern matched no hex glyph
- an_err  out  1  one-cycle pulse: stable AN had more than one bit low
- frame_done  out  1  one-cycle pulse: all 4 digits captured since the previous pulse

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; seen mask 0; stability counter 0.
  - Synchronizer and previous-sample registers load the idle value, AN=4'hF and SEGMENT=8'hFF, so no spurious capture follows reset release.
- Synchronizer: 2-flop synchronizer on all 12 input bits. s = second-stage output.
- Stability detection:
  - cand_q <= s every cycle.
  - If s != cand_q: cnt <= 0.
  - Otherwise cnt increments, saturating at STABLE_CYCLES.
  - A capture fires in the cycle cnt goes from STABLE_CYCLES-1 to STABLE_CYCLES: one capture per stable period.
  - Latency: inputs changing before edge k are captured, with outputs updated, at edge k+3+STABLE_CYCLES.
- Capture, by synchronized AN value:
  - AN = 4'hF: no action.
  - Exactly one bit i low: update digit i (below).
  - More than one bit low: an_err pulses for 1 cycle; no digit, seen or frame state changes.
- Digit update for position i:
  - Lit set L = ~SEGMENT[6:0], ordered gfedcba.
  - points[i] <= ~SEGMENT[7].
  - L = 0: blank[i]=1, seg_err[i]=0, nibble i=0.
  - L matches a glyph: nibble i = glyph value, blank[i]=0, seg_err[i]=0.
  - Otherwise: seg_err[i]=1, blank[i]=0, nibble i=0.
- Glyph table, L in hex, value:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- Frame tracking:
  - seen_next = seen | onehot(i).
  - If seen_next = 4'hF: frame_done pulses in the capture cycle and seen <= 0.
  - Else seen <= seen_next.
  - Recapturing an already-seen digit only refreshes its outputs.
  - Blank and error captures still count as seen.
- Static driver held on one digit: captures once; frame_done never fires.
- Reset mid-frame: partial seen mask and all outputs are discarded; no frame_done is emitted.
- Glitch handling: a glitch shorter than STABLE_CYCLES after synchronization restarts cnt and causes no capture.

Decomposition:
- Package seg7_pkg holds:
  - The 16-entry glyph constant table (7-bit lit patterns, hex index).
  - IDLE_AN = 4'hF and IDLE_SEG = 8'hFF.
  - Field widths DIGITS = 4 and SEG_W = 8.
- Sub-module seg7_pattern_decode (combinational):
  - Input: 7-bit lit set.
  - Outputs: value[3:0], is_blank, is_err.
  - Instanced once; stays reusable for any future segment consumer.

Test Plan:
- Reset then idle: rst_n low, release, inputs 8'hFF/4'hF for 50 cycles -> all outputs 0, no pulses.
- Static digit capture:
  - Stimulus: STABLE_CYCLES=4, AN=4'b1110, SEGMENT=8'b1_0010010 (lit 6D, point off).
  - Response: at edge k+7, digits[3:0]=5, points[0]=0, blank[0]=0, seg_err[0]=0; frame_done never pulses.
- Full scan:
  - Stimulus: scan AN 1110/1101/1011/0111 every 20 cycles with glyphs 3, A, d, 8 and point lit on digit 2.
  - Response: digits=16'h8DA3, points=4'b0100, frame_done pulses once per 4-digit cycle.
- Error and blank:
  - Stimulus: digit 1 with lit set 7'h01, then digit 2 with 8'hFF.
  - Response: seg_err=4'b0010, nibble1=0; blank=4'b0100, nibble2=0; both count toward frame_done.
- Glitch and an_err:
  - Stimulus: SEGMENT held 3 cycles then changed.
  - Response: no capture.
  - Stimulus: stable AN=4'b1100.
  - Response: an_err 1-cycle pulse; digits and seen unchanged.
- Reset mid-frame:
  - Stimulus: capture digits 0 and 1, assert rst_n asynchronously between clk edges, release, then capture digits 2 and 3.
  - Response: outputs 0 immediately on assertion; no frame_done until digits 0 and 1 are captured again.
